instr_mem_loader: RTL and testbench

Byte-serial programmer that fills the instruction memory before execution starts. It takes a stream of bytes over a valid/ready handshake, packs each group of four into a 32-bit instruction word, and issues one write per word at incrementing word addresses from 0. It sits between the host/UART byte source and the write port of the instruction memory. It flags completion so the fetch path can be released.

---
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 tb/tb_instr_mem_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-serial instruction memory programmer: packs four bytes big-endian into
// one word and writes the words to consecutive addresses from 0.
module instr_mem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   longitud,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] direccion,
  output logic [DATA_W-1:0] dato,
  output logic              ocupado,
  output logic              listo,
  output logic              error
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned BUF_W = DATA_W - 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECIBE  = 2'd1,
    ESCRIBE = 2'd2,
    FIN     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic [DATA_W-1:0] dato_q, dato_d;
  logic              byte_ready_q, byte_ready_d;
  logic              we_q, we_d;
  logic              ocupado_q, ocupado_d;
  logic              listo_q, listo_d;
  logic              error_q, error_d;
  logic              len_ok;

  assign len_ok = (longitud != '0) && (longitud <= MAX_LEN);

  // Next-state and next-output logic; outputs are registered from state_d.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    dir_d   = dir_q;
    dato_d  = dato_q;
    error_d = 1'b0;

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          if (len_ok) begin
            len_d   = longitud;
            dir_d   = '0;
            cnt_d   = 2'd0;
            state_d = RECIBE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      RECIBE: begin
        if (byte_valid && byte_ready_q) begin
          if (cnt_q == 2'd3) begin
            dato_d  = {buf_q, byte_in};
            cnt_d   = 2'd0;
            state_d = ESCRIBE;
          end else begin
            buf_d = {buf_q[BUF_W-9:0], byte_in};
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      ESCRIBE: begin
        if (LEN_W'(dir_q) == (len_q - LEN_W'(1))) begin
          state_d = FIN;
        end else begin
          dir_d   = dir_q + ADDR_W'(1);
          state_d = RECIBE;
        end
      end
      default: state_d = IDLE;
    endcase

    byte_ready_d = (state_d == RECIBE);
    we_d         = (state_d == ESCRIBE);
    ocupado_d    = (state_d == RECIBE) || (state_d == ESCRIBE);
    listo_d      = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= 2'd0;
      buf_q        <= '0;
      dir_q        <= '0;
      dato_q       <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      ocupado_q    <= 1'b0;
      listo_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      dir_q        <= dir_d;
      dato_q       <= dato_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      ocupado_q    <= ocupado_d;
      listo_q      <= listo_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign we         = we_q;
  assign direccion  = dir_q;
  assign dato       = dato_q;
  assign ocupado    = ocupado_q;
  assign listo      = listo_q;
  assign error      = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: vector table plus randomized loads
// scored against a word list built from the byte stream.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  longitud = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        we;
  logic [7:0]  direccion;
  logic [31:0] dato;
  logic        ocupado;
  logic        listo;
  logic        error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_W(8), .DATA_W(32), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .longitud   (longitud),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .direccion  (direccion),
    .dato       (dato),
    .ocupado    (ocupado),
    .listo      (listo),
    .error      (error)
  );

  typedef struct {
    logic        rst_n;
    logic        start;
    logic [8:0]  len;
    logic        bv;
    logic [7:0]  b;
    logic        e_br;
    logic        e_we;
    logic [7:0]  e_dir;
    logic [31:0] e_dato;
    logic        e_oc;
    logic        e_li;
    logic        e_err;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(logic r, logic s, logic [8:0] len, logic bv, logic [7:0] b,
                              logic br, logic w, logic [7:0] dir, logic [31:0] d,
                              logic oc, logic li, logic er);
    vec_t v;
    v.rst_n = r; v.start = s; v.len = len; v.bv = bv; v.b = b;
    v.e_br = br; v.e_we = w; v.e_dir = dir; v.e_dato = d;
    v.e_oc = oc; v.e_li = li; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete load of L words; expected writes come from the byte list.
  task automatic run_load(input int L, input int gap_pct, input bit incr, input bit inject);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    int          idx = 0;
    int          wcnt = 0;
    int          budget;
    bit          pre_rdy;
    bit          acc;
    for (int k = 0; k < 4 * L; k++)
      bytes.push_back(incr ? 8'(k) : 8'($urandom));
    start = 1'b1; longitud = 9'(L); byte_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("ld.ocupado_after_start", 32'(ocupado), 32'd1);
    budget = 30 * L + 20;
    while (wcnt < L && budget > 0) begin
      budget--;
      byte_valid = (idx < 4 * L) && (int'($urandom_range(99)) >= gap_pct);
      byte_in    = (idx < 4 * L) ? bytes[idx] : 8'($urandom);
      if (inject && $urandom_range(15) == 0) begin
        start    = 1'b1;
        longitud = 9'($urandom_range(300));
      end
      pre_rdy = byte_ready;
      tick();
      start = 1'b0;
      acc = byte_valid && pre_rdy;
      if (acc) idx++;
      chk("ld.we_timing", 32'(we), 32'(acc && (idx % 4 == 0)));
      chk("ld.error_ignored", 32'(error), 32'd0);
      chk("ld.ocupado", 32'(ocupado), 32'd1);
      if (we) begin
        w = {bytes[4*wcnt], bytes[4*wcnt+1], bytes[4*wcnt+2], bytes[4*wcnt+3]};
        chk("ld.addr", 32'(direccion), 32'(wcnt));
        chk("ld.data", dato, w);
        wcnt++;
      end
    end
    if (wcnt < L) begin
      total++; bad++;
      $display("FAIL ld.timeout writes=%0d required=%0d", wcnt, L);
    end
    byte_valid = 1'b1; byte_in = 8'hEE;
    tick();
    chk("ld.listo", 32'(listo), 32'd1);
    chk("ld.ocupado_fin", 32'(ocupado), 32'd0);
    chk("ld.no_extra_we", 32'(we), 32'd0);
    chk("ld.ready_fin", 32'(byte_ready), 32'd0);
    chk("ld.last_addr", 32'(direccion), 32'(L - 1));
    chk("ld.bytes_taken", 32'(idx), 32'(4 * L));
    byte_valid = 1'b0;
  endtask

  initial begin : main
    int idx;
    int wes;
    int budget;
    bit pre_rdy;

    tab.push_back(mk(0,0,9'd0,  0,8'h00, 0,0,8'h00,32'h0,        0,0,0));
    tab.push_back(mk(0,0,9'd0,  0,8'h00, 0,0,8'h00,32'h0,        0,0,0));
    tab.push_back(mk(1,0,9'd0,  1,8'h55, 0,0,8'h00,32'h0,        0,0,0));
    tab.push_back(mk(1,1,9'd0,  1,8'h55, 0,0,8'h00,32'h0,        0,0,1));
    tab.push_back(mk(1,0,9'd0,  1,8'h55, 0,0,8'h00,32'h0,        0,0,0));
    tab.push_back(mk(1,1,9'd257,0,8'h00, 0,0,8'h00,32'h0,        0,0,1));
    tab.push_back(mk(1,1,9'd1,  0,8'h00, 1,0,8'h00,32'h0,        1,0,0));
    tab.push_back(mk(1,0,9'd0,  1,8'h8C, 1,0,8'h00,32'h0,        1,0,0));
    tab.push_back(mk(1,0,9'd0,  1,8'h01, 1,0,8'h00,32'h0,        1,0,0));
    tab.push_back(mk(1,0,9'd0,  1,8'h00, 1,0,8'h00,32'h0,        1,0,0));
    tab.push_back(mk(1,0,9'd0,  1,8'h04, 0,1,8'h00,32'h8C010004, 1,0,0));
    tab.push_back(mk(1,0,9'd0,  1,8'hAA, 0,0,8'h00,32'h8C010004, 0,1,0));
    tab.push_back(mk(1,1,9'd0,  1,8'hBB, 0,0,8'h00,32'h8C010004, 0,1,1));
    tab.push_back(mk(1,1,9'd1,  0,8'h00, 1,0,8'h00,32'h8C010004, 1,0,0));
    tab.push_back(mk(1,0,9'd0,  1,8'h11, 1,0,8'h00,32'h8C010004, 1,0,0));
    tab.push_back(mk(1,0,9'd0,  1,8'h22, 1,0,8'h00,32'h8C010004, 1,0,0));
    tab.push_back(mk(1,1,9'd5,  0,8'h00, 1,0,8'h00,32'h8C010004, 1,0,0));
    tab.push_back(mk(0,0,9'd0,  1,8'h33, 0,0,8'h00,32'h0,        0,0,0));
    tab.push_back(mk(1,0,9'd0,  1,8'h44, 0,0,8'h00,32'h0,        0,0,0));

    for (int i = 0; i < tab.size(); i++) begin
      rst_n = tab[i].rst_n; start = tab[i].start; longitud = tab[i].len;
      byte_valid = tab[i].bv; byte_in = tab[i].b;
      tick();
      chk($sformatf("vec%0d.byte_ready", i), 32'(byte_ready), 32'(tab[i].e_br));
      chk($sformatf("vec%0d.we", i),         32'(we),         32'(tab[i].e_we));
      chk($sformatf("vec%0d.direccion", i),  32'(direccion),  32'(tab[i].e_dir));
      chk($sformatf("vec%0d.dato", i),       dato,            tab[i].e_dato);
      chk($sformatf("vec%0d.ocupado", i),    32'(ocupado),    32'(tab[i].e_oc));
      chk($sformatf("vec%0d.listo", i),      32'(listo),      32'(tab[i].e_li));
      chk($sformatf("vec%0d.error", i),      32'(error),      32'(tab[i].e_err));
    end
    start = 1'b0; byte_valid = 1'b0;

    run_load(3, 50, 1'b0, 1'b0);
    run_load(3, 40, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++)
      run_load(int'($urandom_range(1, 8)), int'($urandom_range(0, 60)), 1'b0, 1'b1);
    run_load(256, 0, 1'b1, 1'b0);

    // Abort a two-word load after two bytes of the second word.
    start = 1'b1; longitud = 9'd2;
    tick();
    start = 1'b0;
    idx = 0; wes = 0; budget = 40;
    while (idx < 6 && budget > 0) begin
      budget--;
      byte_valid = 1'b1; byte_in = 8'(8'hA0 + idx);
      pre_rdy = byte_ready;
      tick();
      if (pre_rdy) idx++;
      if (we) wes++;
    end
    chk("abort.bytes_taken", 32'(idx), 32'd6);
    chk("abort.writes_before", 32'(wes), 32'd1);
    chk("abort.addr_before", 32'(direccion), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort.byte_ready", 32'(byte_ready), 32'd0);
    chk("abort.we", 32'(we), 32'd0);
    chk("abort.direccion", 32'(direccion), 32'd0);
    chk("abort.dato", dato, 32'd0);
    chk("abort.ocupado", 32'(ocupado), 32'd0);
    chk("abort.listo", 32'(listo), 32'd0);
    chk("abort.error", 32'(error), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort.idle_we", 32'(we), 32'd0);
      chk("abort.idle_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    run_load(1, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
